// File: rtl/count_checker.sv
// count_checker: tracks an 8-bit counter against a load/increment model.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   count_in, oe_n_in - observed counter bus; valid when oe_n_in is low
//   load_in, data_in  - observed load strobe and 6-bit load data
//   expected          - model value predicted for the current cycle
//   locked, mismatch  - lock status and one-cycle locked-mismatch pulse
//   err_cnt           - saturating count of locked mismatches
//   rd_en, rd_data    - mismatch log pop; entry is {expected, observed}
//   rd_valid          - rd_data freshly popped this cycle
//   log_empty/full    - registered log occupancy flags
//   log_ovf           - sticky: an entry was dropped while full
module count_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOG_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  count_in,
    input  logic        oe_n_in,
    input  logic        load_in,
    input  logic [5:0]  data_in,
    output logic [7:0]  expected,
    output logic        locked,
    output logic        mismatch,
    output logic [7:0]  err_cnt,
    input  logic        rd_en,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        log_empty,
    output logic        log_full,
    output logic        log_ovf
);

    localparam int AW = $clog2(LOG_DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    localparam logic [3:0] LOCK_N  = 4'(LOCK_COUNT);
    localparam cnt_t       DEPTH_N = cnt_t'(LOG_DEPTH);

    typedef enum logic [1:0] {
        ACQUIRE,
        VERIFY,
        LOCKED
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  exp_q, exp_nxt;
    logic [3:0]  run_q, run_nxt;
    logic [7:0]  err_nxt;
    logic        mis_nxt;
    logic        push;
    logic        valid, hit;
    logic [7:0]  model, seed;

    logic [15:0] mem [LOG_DEPTH];
    ptr_t        wr_ptr, rd_ptr;
    cnt_t        cnt_q, cnt_nxt;
    logic        do_push, do_pop;

    assign expected = exp_q;
    assign locked   = (state == LOCKED);

    always_comb begin
        valid     = !oe_n_in;
        hit       = (count_in == exp_q);
        model     = load_in ? {2'b00, data_in} : exp_q + 8'd1;
        // Reseed trusts the observed bus rather than the stale model.
        seed      = load_in ? {2'b00, data_in} : count_in + 8'd1;
        state_nxt = state;
        exp_nxt   = model;
        run_nxt   = run_q;
        err_nxt   = err_cnt;
        mis_nxt   = 1'b0;
        push      = 1'b0;
        if (valid) begin
            unique case (state)
                ACQUIRE: begin
                    exp_nxt   = seed;
                    run_nxt   = 4'd1;
                    state_nxt = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
                end
                VERIFY: begin
                    if (hit) begin
                        run_nxt = run_q + 4'd1;
                        if (run_nxt >= LOCK_N)
                            state_nxt = LOCKED;
                    end else begin
                        exp_nxt = seed;
                        run_nxt = 4'd1;
                        if (LOCK_N == 4'd1)
                            state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (!hit) begin
                        mis_nxt   = 1'b1;
                        push      = 1'b1;
                        err_nxt   = (err_cnt == 8'hFF) ? err_cnt
                                                       : err_cnt + 8'd1;
                        exp_nxt   = seed;
                        run_nxt   = 4'd1;
                        state_nxt = VERIFY;
                    end
                end
                default: state_nxt = ACQUIRE;
            endcase
        end
    end

    // Pop only sees the registered occupancy, so a push into an empty
    // log is never visible on the same edge.
    always_comb begin
        do_pop  = rd_en && !log_empty;
        do_push = push && (!log_full || do_pop);
        cnt_nxt = cnt_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push)
            mem[wr_ptr] <= {exp_q, count_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACQUIRE;
            exp_q     <= 8'd0;
            run_q     <= 4'd0;
            mismatch  <= 1'b0;
            err_cnt   <= 8'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            log_empty <= 1'b1;
            log_full  <= 1'b0;
            log_ovf   <= 1'b0;
            rd_data   <= 16'd0;
            rd_valid  <= 1'b0;
        end else begin
            state    <= state_nxt;
            exp_q    <= exp_nxt;
            run_q    <= run_nxt;
            mismatch <= mis_nxt;
            err_cnt  <= err_nxt;
            if (do_push)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop) begin
                rd_ptr  <= rd_ptr + ptr_t'(1);
                rd_data <= mem[rd_ptr];
            end
            rd_valid  <= do_pop;
            cnt_q     <= cnt_nxt;
            log_empty <= (cnt_nxt == '0);
            log_full  <= (cnt_nxt == DEPTH_N);
            if (push && !do_push)
                log_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: directed and randomized checks of count_checker
// against a queue-based behavioural model.
module tb_count_checker;

    localparam int LC    = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  count_in;
    logic        oe_n_in;
    logic        load_in;
    logic [5:0]  data_in;
    logic [7:0]  expected;
    logic        locked;
    logic        mismatch;
    logic [7:0]  err_cnt;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        log_empty;
    logic        log_full;
    logic        log_ovf;

    count_checker #(.LOCK_COUNT(LC), .LOG_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .count_in(count_in),
        .oe_n_in(oe_n_in), .load_in(load_in), .data_in(data_in),
        .expected(expected), .locked(locked), .mismatch(mismatch),
        .err_cnt(err_cnt), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .log_empty(log_empty),
        .log_full(log_full), .log_ovf(log_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: 0 = acquiring, 1 = verifying, 2 = locked
    int          m_exp, m_run, m_mode, m_err;
    logic [15:0] m_q[$];
    bit          m_ovf, m_mis, m_rdv;
    logic [15:0] m_rd;

    task automatic cyc(input bit r, input bit oe, input int c,
                       input bit ld, input int d, input bit rd);
        int          adv, seed, psz;
        bit          pushv, popok;
        logic [15:0] pval;
        reset    = r;
        oe_n_in  = oe;
        count_in = 8'(c);
        load_in  = ld;
        data_in  = 6'(d);
        rd_en    = rd;
        adv   = ld ? d % 64 : (m_exp + 1) % 256;
        seed  = ld ? d % 64 : (c + 1) % 256;
        pushv = 0;
        pval  = '0;
        m_mis = 0;
        if (r) begin
            m_exp = 0; m_run = 0; m_mode = 0; m_err = 0;
            m_q.delete(); m_ovf = 0; m_rd = '0; m_rdv = 0;
        end else begin
            if (oe) begin
                m_exp = adv;
            end else if (m_mode == 0) begin
                m_exp = seed; m_run = 1; m_mode = 1;
            end else if (c == m_exp) begin
                m_exp = adv;
                if (m_mode == 1) begin
                    m_run++;
                    if (m_run >= LC) m_mode = 2;
                end
            end else begin
                if (m_mode == 2) begin
                    m_mis = 1; pushv = 1;
                    pval = {8'(m_exp), 8'(c)};
                    if (m_err < 255) m_err++;
                    m_mode = 1;
                end
                m_exp = seed; m_run = 1;
            end
            psz   = m_q.size();
            popok = rd && psz > 0;
            if (popok) m_rd = m_q.pop_front();
            m_rdv = popok;
            if (pushv) begin
                if (psz < DEPTH || popok) m_q.push_back(pval);
                else m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic relock();
        for (int i = 0; i < 12 && m_mode != 2; i++)
            cyc(0, 0, m_exp, 0, 0, 0);
        n_cmp++;
        if (locked !== 1'b1 || m_mode != 2) begin
            n_bad++;
            $display("FAIL relock: locked=%0b required 1", locked);
        end
    endtask

    task automatic bad(input bit rd);
        cyc(0, 0, (m_exp + 128) % 256, 0, 0, rd);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 300 && m_exp != target; i++)
            cyc(0, 0, m_exp, 0, 0, 0);
        n_cmp++;
        if (expected !== 8'(target)) begin
            n_bad++;
            $display("FAIL run_to: expected=%h required %h",
                     expected, 8'(target));
        end
    endtask

    task automatic test_reset();
        cyc(1, 0, 8'h33, 1, 5, 1);
        cyc(1, 0, 8'h44, 1, 9, 1);
        n_cmp++;
        if ({expected, locked, mismatch, err_cnt} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_core: exp=%h lk=%b mis=%b err=%h req 0",
                     expected, locked, mismatch, err_cnt);
        end
        n_cmp++;
        if ({rd_data, rd_valid, log_empty, log_full, log_ovf}
            !== {16'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_log: rd=%h v=%b e=%b f=%b o=%b req 0/0/1/0/0",
                     rd_data, rd_valid, log_empty, log_full, log_ovf);
        end
    endtask

    task automatic test_lockup();
        cyc(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            cyc(0, 0, c, 0, 0, 0);
            n_cmp++;
            if (locked !== (c == 3)) begin
                n_bad++;
                $display("FAIL lockup_locked: sample %0d locked=%b req %b",
                         c, locked, (c == 3));
            end
        end
        cyc(0, 0, 4, 0, 0, 0);
        n_cmp++;
        if (expected !== 8'd5 || err_cnt !== 8'd0 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL lockup_after: exp=%h err=%h lk=%b req 05/00/1",
                     expected, err_cnt, locked);
        end
    endtask

    task automatic test_load();
        run_to(8'h10);
        cyc(0, 0, 8'h10, 1, 8'h2A, 0);
        n_cmp++;
        if (expected !== 8'h2A) begin
            n_bad++;
            $display("FAIL load_exp: expected=%h required 2a", expected);
        end
        cyc(0, 0, 8'h2A, 0, 0, 0);
        n_cmp++;
        if (mismatch !== 1'b0 || locked !== 1'b1 || expected !== 8'h2B) begin
            n_bad++;
            $display("FAIL load_track: mis=%b lk=%b exp=%h req 0/1/2b",
                     mismatch, locked, expected);
        end
    endtask

    task automatic test_wrap_gap();
        run_to(8'hFE);
        cyc(0, 0, 8'hFE, 0, 0, 0);
        cyc(0, 0, 8'hFF, 0, 0, 0);
        n_cmp++;
        if (expected !== 8'h00) begin
            n_bad++;
            $display("FAIL wrap: expected=%h required 00", expected);
        end
        cyc(0, 1, 8'h99, 0, 0, 0);
        cyc(0, 1, 8'h13, 0, 0, 0);
        n_cmp++;
        if (expected !== 8'h02 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL gap: exp=%h lk=%b req 02/1", expected, locked);
        end
        cyc(0, 0, 8'h02, 0, 0, 0);
        n_cmp++;
        if (mismatch !== 1'b0 || locked !== 1'b1 || err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL gap_resume: mis=%b lk=%b err=%h req 0/1/00",
                     mismatch, locked, err_cnt);
        end
    endtask

    task automatic test_locked_error();
        run_to(8'h40);
        cyc(0, 0, 8'h55, 0, 0, 0);
        n_cmp++;
        if (mismatch !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0
            || log_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL lerr: mis=%b err=%h lk=%b e=%b req 1/01/0/0",
                     mismatch, err_cnt, locked, log_empty);
        end
        cyc(0, 0, 8'h56, 0, 0, 1);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h4055
            || log_empty !== 1'b1 || mismatch !== 1'b0) begin
            n_bad++;
            $display("FAIL lerr_pop: v=%b rd=%h e=%b mis=%b req 1/4055/1/0",
                     rd_valid, rd_data, log_empty, mismatch);
        end
        cyc(0, 0, 8'h57, 0, 0, 0);
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h4055) begin
            n_bad++;
            $display("FAIL lerr_hold: v=%b rd=%h req 0/4055",
                     rd_valid, rd_data);
        end
    endtask

    logic [15:0] ent[5];

    task automatic test_overflow();
        cyc(1, 0, 0, 0, 0, 0);
        relock();
        for (int k = 0; k < 5; k++) begin
            ent[k] = {8'(m_exp), 8'((m_exp + 128) % 256)};
            bad(0);
            if (k == 3) begin
                n_cmp++;
                if (log_full !== 1'b1 || log_ovf !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ovf_fill: f=%b o=%b req 1/0",
                             log_full, log_ovf);
                end
            end
            relock();
        end
        n_cmp++;
        if (log_full !== 1'b1 || log_ovf !== 1'b1 || err_cnt !== 8'd5) begin
            n_bad++;
            $display("FAIL ovf: f=%b o=%b err=%h req 1/1/05",
                     log_full, log_ovf, err_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, m_exp, 0, 0, 1);
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== ent[k]) begin
                n_bad++;
                $display("FAIL ovf_pop%0d: v=%b rd=%h req 1/%h",
                         k, rd_valid, rd_data, ent[k]);
            end
        end
        cyc(0, 0, m_exp, 0, 0, 1);
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_data !== ent[3] || log_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_pop_empty: v=%b rd=%h e=%b req 0/%h/1",
                     rd_valid, rd_data, log_empty, ent[3]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e[5];
        e[0] = {8'(m_exp), 8'((m_exp + 128) % 256)};
        bad(1);
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_data !== ent[3]
            || log_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_empty: v=%b rd=%h e=%b req 0/%h/0",
                     rd_valid, rd_data, log_empty, ent[3]);
        end
        relock();
        for (int k = 1; k < 4; k++) begin
            e[k] = {8'(m_exp), 8'((m_exp + 128) % 256)};
            bad(0);
            relock();
        end
        e[4] = {8'(m_exp), 8'((m_exp + 128) % 256)};
        bad(1);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== e[0] || log_full !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_full: v=%b rd=%h f=%b req 1/%h/1",
                     rd_valid, rd_data, log_full, e[0]);
        end
        for (int k = 1; k < 5; k++) begin
            cyc(0, 0, m_exp, 0, 0, 1);
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== e[k]) begin
                n_bad++;
                $display("FAIL b2b_pop%0d: v=%b rd=%h req 1/%h",
                         k, rd_valid, rd_data, e[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 0, 0, 0, 0);
        relock();
        for (int k = 0; k < 3; k++) begin
            bad(0);
            relock();
        end
        n_cmp++;
        if (err_cnt !== 8'd3 || log_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_pre: err=%h e=%b req 03/0",
                     err_cnt, log_empty);
        end
        cyc(1, 0, (m_exp + 128) % 256, 1, 7, 1);
        n_cmp++;
        if ({expected, locked, mismatch, err_cnt} !== 18'd0) begin
            n_bad++;
            $display("FAIL rmid_core: exp=%h lk=%b mis=%b err=%h req 0",
                     expected, locked, mismatch, err_cnt);
        end
        n_cmp++;
        if ({rd_data, rd_valid, log_empty, log_full, log_ovf}
            !== {16'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL rmid_log: rd=%h v=%b e=%b f=%b o=%b req 0/0/1/0/0",
                     rd_data, rd_valid, log_empty, log_full, log_ovf);
        end
        cyc(0, 0, 8'h77, 0, 0, 0);
        cyc(0, 0, 8'h78, 0, 0, 0);
        n_cmp++;
        if (locked !== 1'b0 || expected !== 8'h79 || mismatch !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_verify: lk=%b exp=%h mis=%b req 0/79/0",
                     locked, expected, mismatch);
        end
    endtask

    task automatic test_random();
        bit r, oe, ld, rd;
        int c, d, pr;
        logic [44:0] got, want;
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            pr = ((i / 300) % 2 == 1) ? 35 : 3;
            r  = ($urandom_range(0, 299) == 0);
            oe = ($urandom_range(0, 7) == 0);
            ld = ($urandom_range(0, 15) == 0);
            d  = $urandom_range(0, 63);
            c  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                              : m_exp;
            rd = ($urandom_range(0, 99) < pr);
            cyc(r, oe, c, ld, d, rd);
            got  = {expected, locked, mismatch, err_cnt, rd_valid,
                    rd_data, log_empty, log_full, log_ovf};
            want = {8'(m_exp), m_mode == 2, m_mis, 8'(m_err), m_rdv,
                    m_rd, m_q.size() == 0, m_q.size() == DEPTH, m_ovf};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h required %h",
                         i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lockup();
        test_load();
        test_wrap_gap();
        test_locked_error();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 The block SHALL have the parameter LOCK_COUNT, default 4, meaning consecutive matching valid samples needed to assert locked (range 1..15).
REQ-002 The block SHALL have the parameter LOG_DEPTH, default 4, meaning the number of mismatch-log entries (power of 2, range 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port count_in, input, 8 bits: the observed counter output bus.
REQ-006 The block SHALL have port oe_n_in, input, 1 bit: the observed counter output enable; low means count_in is valid.
REQ-007 The block SHALL have port load_in, input, 1 bit: the observed counter load strobe.
REQ-008 The block SHALL have port data_in, input, 6 bits: the observed counter load data.
REQ-009 The block SHALL have port expected, output, 8 bits: the model value predicted for the current cycle.
REQ-010 The block SHALL have port locked, output, 1 bit: high while in LOCKED state.
REQ-011 The block SHALL have port mismatch, output, 1 bit: a one-cycle pulse on a LOCKED-state mismatch.
REQ-012 The block SHALL have port err_cnt, output, 8 bits: the saturating count of LOCKED-state mismatches.
REQ-013 The block SHALL have port rd_en, input, 1 bit: the log pop request.
REQ-014 The block SHALL have port rd_data, output, 16 bits: the popped log entry {expected[7:0], observed[7:0]}.
REQ-015 The block SHALL have port rd_valid, output, 1 bit: high for the one cycle in which rd_data is fresh.
REQ-016 The block SHALL have ports log_empty, log_full and log_ovf, outputs, 1 bit each: log status; log_ovf is sticky.

Function
REQ-017 The reference model SHALL be exp(t+1) = {2'b00, data_in(t)} when load_in(t)=1, else exp(t)+1 mod 256; 255 wraps to 0.
REQ-018 A sample SHALL be valid only when oe_n_in=0; when oe_n_in=1 there is no comparison and no state or run change, but the model still advances per REQ-017.
REQ-019 The FSM SHALL have the states ACQUIRE, VERIFY and LOCKED.
REQ-020 ACQUIRE: on the first valid sample, the block SHALL seed exp(t+1) = load_in ? {00,data_in} : count_in+1, set run=1, and go to VERIFY (LOCKED when LOCK_COUNT=1).
REQ-021 VERIFY: on a valid match, run SHALL increment and the FSM SHALL go to LOCKED when run reaches LOCK_COUNT.
REQ-022 VERIFY: on a valid mismatch, the block SHALL reseed from count_in per REQ-020 and set run=1, with no error count and no log push.
REQ-023 LOCKED: on a valid mismatch, the block SHALL, in the same edge, pulse mismatch for 1 cycle, increment err_cnt (saturating at 255), push {expected, count_in} to the log, reseed from count_in, set run=1 and go to VERIFY.
REQ-024 locked SHALL fall the cycle after the mismatch edge.
REQ-025 The log SHALL be a LOG_DEPTH-entry FIFO.
REQ-026 A push while full with no pop SHALL drop the entry and set log_ovf until reset.
REQ-027 A simultaneous push and pop while full SHALL accept both, and the FIFO SHALL stay full.
REQ-028 A simultaneous push and pop while empty SHALL return the old rd_data, with rd_valid=0, and the new entry SHALL be stored; push-to-pop fall-through is not allowed.
REQ-029 rd_en on a non-empty log SHALL give rd_data and rd_valid=1 on the next cycle.
REQ-030 rd_en on an empty log SHALL be ignored: rd_valid=0 and rd_data is held.
REQ-031 log_empty and log_full SHALL be registered and SHALL reflect occupancy after each edge.

Reset
REQ-032 While reset=1 at a clk edge, the block SHALL set state=ACQUIRE, exp/expected=0, run=0, locked=0, mismatch=0, err_cnt=0, rd_data=0, rd_valid=0, log pointers=0, log_empty=1, log_full=0 and log_ovf=0.
REQ-033 A reset asserted mid-operation SHALL discard log contents and lock status on that edge.
REQ-034 A reset asserted mid-operation SHALL override a same-cycle load_in, rd_en or mismatch.
REQ-035 The first edge after reset deasserts SHALL behave as ACQUIRE.

Verification
REQ-036 The bench SHALL cover lock-up: reset, then count_in=0,1,2,3,4 on consecutive cycles with oe_n_in=0 -> locked=1 after the 4th matching sample, expected=5 next, err_cnt=0.
REQ-037 The bench SHALL cover load tracking: while LOCKED at count 0x10, load_in=1 with data_in=0x2A for one cycle, next count_in=0x2A -> no mismatch, locked stays 1, expected=0x2B the following cycle.
REQ-038 The bench SHALL cover wrap and gap: count_in 0xFE,0xFF, then oe_n_in=1 for 2 cycles, then count_in=0x02 -> no mismatch, locked stays 1.
REQ-039 The bench SHALL cover a LOCKED error: at expected=0x40 drive count_in=0x55 -> mismatch pulse, err_cnt=1, locked=0 next cycle, log holds 0x4055; rd_en -> rd_data=0x4055 and rd_valid=1 next cycle, log_empty=1.
REQ-040 The bench SHALL cover log overflow: 5 LOCKED mismatches with LOG_DEPTH=4 and no pops -> log_full=1, log_ovf=1, err_cnt=5; 4 pops return entries in order, and a 5th pop gives rd_valid=0.
REQ-041 The bench SHALL cover reset mid-operation: reset=1 for 1 cycle while locked with err_cnt=3 and the log non-empty -> all outputs at REQ-032 values; the next valid sample re-enters VERIFY.
